// File: rtl/axi_tdd_pkg.sv
// Shared TDD types.
// Channels import this package for the sequencer state encoding.
package axi_tdd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      WAITING = 2'd2,
      RUNNING = 2'd3
   } state_t;

endpackage

// File: rtl/axi_tdd_sequencer_if.sv
// Frame timing bus from the sequencer to every TDD channel.
// The sequencer drives it as master; channels listen as slave.
interface axi_tdd_sequencer_if #(
   parameter int REGISTER_WIDTH = 32
);
   import axi_tdd_pkg::*;

   logic                      tdd_enable;
   state_t                    tdd_cstate;
   logic [REGISTER_WIDTH-1:0] tdd_counter;
   logic                      tdd_endof_frame;
   logic                      tdd_sync_out;

   modport master (
      output tdd_enable,
      output tdd_cstate,
      output tdd_counter,
      output tdd_endof_frame,
      output tdd_sync_out
   );

   modport slave (
      input tdd_enable,
      input tdd_cstate,
      input tdd_counter,
      input tdd_endof_frame,
      input tdd_sync_out
   );

endinterface

// File: rtl/axi_tdd_sync_detect.sv
// External sync conditioning: optional 2-FF synchronizer
// followed by a registered rising-edge detector.
module axi_tdd_sync_detect #(
   parameter int SYNC_EXT_CDC = 1
) (
   input  logic clk,
   input  logic resetn,
   input  logic sync_ext,
   output logic sync_pulse
);

   logic sync_s;
   logic sync_q;

   generate
      if (SYNC_EXT_CDC != 0) begin : g_cdc
         logic [1:0] meta;

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               meta <= 2'b00;
            end else begin
               meta <= {meta[0], sync_ext};
            end
         end

         assign sync_s = meta[1];
      end else begin : g_nocdc
         assign sync_s = sync_ext;
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q     <= 1'b0;
         sync_pulse <= 1'b0;
      end else begin
         sync_q     <= sync_s;
         sync_pulse <= sync_s & ~sync_q;
      end
   end

endmodule

// File: rtl/axi_tdd_sequencer.sv
// TDD frame timing engine: state machine, frame counter,
// start-up delay, burst count and sync triggering.
module axi_tdd_sequencer #(
   parameter int REGISTER_WIDTH    = 32,
   parameter int BURST_COUNT_WIDTH = 32,
   parameter int SYNC_EXT_CDC      = 1
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         asy_enable,
   input  logic                         asy_sync_int,
   input  logic                         asy_sync_reset,
   input  logic [REGISTER_WIDTH-1:0]    asy_startup_delay,
   input  logic [REGISTER_WIDTH-1:0]    asy_frame_length,
   input  logic [BURST_COUNT_WIDTH-1:0] asy_burst_count,
   input  logic                         sync_ext,
   input  logic                         sync_soft,
   axi_tdd_sequencer_if.master          tdd
);
   import axi_tdd_pkg::*;

   localparam int RW = REGISTER_WIDTH;
   localparam int BW = BURST_COUNT_WIDTH;
   localparam logic [RW-1:0] R_ONE = RW'(1);
   localparam logic [BW-1:0] B_ONE = BW'(1);

   state_t          state_q, state_d;
   logic [RW-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]   rem_q, rem_d;
   logic [RW-1:0]   dly_q;
   logic [RW-1:0]   len_q;
   logic [BW-1:0]   burst_q;
   logic            enable_q;
   logic            eof_q, eof_d;
   logic            sync_q, sync_d;
   logic            intp_q, intp_d;
   logic            capture;
   logic            restart;
   logic            trigger;
   logic            ext_pulse;
   logic            wait_last;
   logic            frame_last;

   axi_tdd_sync_detect #(
      .SYNC_EXT_CDC (SYNC_EXT_CDC)
   ) u_sync_detect (
      .clk        (clk),
      .resetn     (resetn),
      .sync_ext   (sync_ext),
      .sync_pulse (ext_pulse)
   );

   assign trigger    = intp_q | ext_pulse | sync_soft;
   assign wait_last  = (cnt_q == dly_q - R_ONE);
   assign frame_last = (cnt_q == len_q - R_ONE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      sync_d  = 1'b0;
      intp_d  = 1'b0;
      capture = 1'b0;
      restart = 1'b0;
      if (!enable_q) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = ARMED;
               cnt_d   = '0;
               capture = 1'b1;
               intp_d  = asy_sync_int;
            end
            ARMED: begin
               cnt_d   = '0;
               restart = trigger;
            end
            WAITING: begin
               if (trigger && asy_sync_reset) begin
                  restart = 1'b1;
               end else if (wait_last) begin
                  state_d = RUNNING;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + R_ONE;
               end
            end
            RUNNING: begin
               if (trigger && asy_sync_reset) begin
                  restart = 1'b1;
               end else if (frame_last) begin
                  cnt_d = '0;
                  // burst_q == 0 means free-running
                  if (burst_q != '0) begin
                     rem_d = rem_q - B_ONE;
                     if (rem_q == B_ONE) begin
                        state_d = ARMED;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + R_ONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
         if (restart) begin
            state_d = (dly_q != '0) ? WAITING : RUNNING;
            cnt_d   = '0;
            rem_d   = burst_q;
            sync_d  = 1'b1;
         end
      end
      eof_d = (state_d == RUNNING) && (cnt_d == len_q - R_ONE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         enable_q <= 1'b0;
         eof_q    <= 1'b0;
         sync_q   <= 1'b0;
         intp_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         enable_q <= asy_enable;
         eof_q    <= eof_d;
         sync_q   <= sync_d;
         intp_q   <= intp_d;
      end
   end

   // Config is quasi-static and only sampled on arm.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dly_q   <= '0;
         len_q   <= '0;
         burst_q <= '0;
      end else if (capture) begin
         dly_q   <= asy_startup_delay;
         len_q   <= (asy_frame_length == '0) ? R_ONE
                                             : asy_frame_length;
         burst_q <= asy_burst_count;
      end
   end

   assign tdd.tdd_enable      = enable_q;
   assign tdd.tdd_cstate      = state_q;
   assign tdd.tdd_counter     = cnt_q;
   assign tdd.tdd_endof_frame = eof_q;
   assign tdd.tdd_sync_out    = sync_q;

endmodule

// File: tb/tb_axi_tdd_sequencer.sv
// Self-checking bench for axi_tdd_sequencer: scenario table,
// directed corner sequences and random traffic vs a reference model.
module tb_axi_tdd_sequencer;
   import axi_tdd_pkg::*;

   localparam int RW = 32;
   localparam int BW = 32;

   logic          clk = 1'b0;
   logic          resetn;
   logic          asy_enable;
   logic          asy_sync_int;
   logic          asy_sync_reset;
   logic [RW-1:0] asy_startup_delay;
   logic [RW-1:0] asy_frame_length;
   logic [BW-1:0] asy_burst_count;
   logic          sync_ext;
   logic          sync_soft;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   axi_tdd_sequencer_if #(.REGISTER_WIDTH(RW)) tdd ();

   axi_tdd_sequencer #(
      .REGISTER_WIDTH    (RW),
      .BURST_COUNT_WIDTH (BW),
      .SYNC_EXT_CDC      (1)
   ) dut (
      .clk               (clk),
      .resetn            (resetn),
      .asy_enable        (asy_enable),
      .asy_sync_int      (asy_sync_int),
      .asy_sync_reset    (asy_sync_reset),
      .asy_startup_delay (asy_startup_delay),
      .asy_frame_length  (asy_frame_length),
      .asy_burst_count   (asy_burst_count),
      .sync_ext          (sync_ext),
      .sync_soft         (sync_soft),
      .tdd               (tdd)
   );

   // Reference model: frames counted up, eof derived from position.
   typedef struct packed {
      state_t        st;
      logic [RW-1:0] cnt;
      logic [RW-1:0] dly;
      logic [RW-1:0] len;
      logic [BW-1:0] burst;
      logic [BW-1:0] done;
      logic          en;
      logic          intp;
      logic          sync;
      logic [3:0]    hist;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t mstep(mdl_t c);
      mdl_t n;
      logic trig;
      logic start;
      n      = c;
      n.hist = {c.hist[2:0], sync_ext};
      n.en   = asy_enable;
      n.intp = 1'b0;
      n.sync = 1'b0;
      start  = 1'b0;
      trig   = c.intp | (c.hist[2] & ~c.hist[3]) | sync_soft;
      if (!c.en) begin
         n.st  = IDLE;
         n.cnt = 0;
      end else if (c.st == IDLE) begin
         n.st    = ARMED;
         n.cnt   = 0;
         n.dly   = asy_startup_delay;
         n.len   = (asy_frame_length == 0) ? 32'd1 : asy_frame_length;
         n.burst = asy_burst_count;
         n.intp  = asy_sync_int;
      end else if (c.st == ARMED) begin
         start = trig;
      end else if (trig && asy_sync_reset) begin
         start = 1'b1;
      end else if (c.st == WAITING) begin
         if (c.cnt + 1 == c.dly) begin
            n.st  = RUNNING;
            n.cnt = 0;
         end else begin
            n.cnt = c.cnt + 1;
         end
      end else begin
         if (c.cnt + 1 == c.len) begin
            n.cnt  = 0;
            n.done = c.done + 1;
            if (c.burst != 0 && c.done + 1 == c.burst) n.st = ARMED;
         end else begin
            n.cnt = c.cnt + 1;
         end
      end
      if (start) begin
         n.st   = (c.dly != 0) ? WAITING : RUNNING;
         n.cnt  = 0;
         n.done = 0;
         n.sync = 1'b1;
      end
      return n;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) m <= '0;
      else         m <= mstep(m);
   end

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step_cmp();
      logic exp_eof;
      @(posedge clk);
      @(negedge clk);
      exp_eof = (m.st == RUNNING) && (m.cnt + 1 == m.len);
      chk("model_enable", tdd.tdd_enable, m.en);
      chk("model_cstate", tdd.tdd_cstate, m.st);
      chk("model_counter", tdd.tdd_counter, m.cnt);
      chk("model_eof", tdd.tdd_endof_frame, exp_eof);
      chk("model_sync_out", tdd.tdd_sync_out, m.sync);
   endtask

   task automatic go_idle();
      asy_enable = 1'b0;
      repeat (3) step_cmp();
   endtask

   task automatic wait_run(int c);
      bit ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (tdd.tdd_cstate == RUNNING && tdd.tdd_counter == c) begin
            ok = 1'b1;
            break;
         end
         step_cmp();
      end
      chk("wait_running", ok, 1);
   endtask

   typedef struct {
      int     sint;
      int     dly;
      int     len;
      int     burst;
      int     soft_at;
      int     cycles;
      int     eofs;
      int     syncs;
      state_t fin;
   } rec_t;

   rec_t recs[6];

   task automatic restart_test(logic mode);
      int ns;
      go_idle();
      asy_sync_int = 1'b1; asy_sync_reset = mode;
      asy_startup_delay = 0; asy_frame_length = 8; asy_burst_count = 0;
      asy_enable = 1'b1;
      wait_run(2);
      sync_ext = 1'b1;
      repeat (3) step_cmp();
      chk("restart_pre_cnt", tdd.tdd_counter, 5);
      step_cmp();
      chk("restart_cnt", tdd.tdd_counter, mode ? 0 : 6);
      chk("restart_sync", tdd.tdd_sync_out, mode);
      ns = 0;
      repeat (20) begin
         step_cmp();
         ns += int'(tdd.tdd_sync_out);
      end
      chk("ext_held_once", ns, 0);
      sync_ext = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int neo;
      int nsy;
      resetn = 1'b0;
      asy_enable = 1'b0; asy_sync_int = 1'b0; asy_sync_reset = 1'b0;
      asy_startup_delay = 0; asy_frame_length = 0; asy_burst_count = 0;
      sync_ext = 1'b0; sync_soft = 1'b0;

      recs[0] = '{1, 0, 4, 2, -1, 14,  2, 1, ARMED};
      recs[1] = '{0, 3, 5, 1,  3, 14,  1, 1, ARMED};
      recs[2] = '{1, 0, 2, 0, -1, 30, 14, 1, RUNNING};
      recs[3] = '{1, 0, 0, 0, -1, 10,  8, 1, RUNNING};
      recs[4] = '{1, 2, 1, 3, -1, 12,  3, 1, ARMED};
      recs[5] = '{0, 0, 3, 0, -1,  8,  0, 0, ARMED};

      repeat (2) @(negedge clk);
      chk("rst_enable", tdd.tdd_enable, 0);
      chk("rst_cstate", tdd.tdd_cstate, IDLE);
      chk("rst_counter", tdd.tdd_counter, 0);
      chk("rst_eof", tdd.tdd_endof_frame, 0);
      chk("rst_sync", tdd.tdd_sync_out, 0);
      resetn = 1'b1;

      foreach (recs[r]) begin
         go_idle();
         asy_sync_int      = recs[r].sint[0];
         asy_sync_reset    = 1'b0;
         asy_startup_delay = recs[r].dly;
         asy_frame_length  = recs[r].len;
         asy_burst_count   = recs[r].burst;
         asy_enable        = 1'b1;
         neo = 0;
         nsy = 0;
         for (int i = 0; i < recs[r].cycles; i++) begin
            sync_soft = (i == recs[r].soft_at);
            step_cmp();
            neo += int'(tdd.tdd_endof_frame);
            nsy += int'(tdd.tdd_sync_out);
         end
         sync_soft = 1'b0;
         chk($sformatf("rec%0d_eofs", r), neo, recs[r].eofs);
         chk($sformatf("rec%0d_syncs", r), nsy, recs[r].syncs);
         chk($sformatf("rec%0d_state", r), tdd.tdd_cstate, recs[r].fin);
      end

      restart_test(1'b1);
      restart_test(1'b0);

      go_idle();
      asy_sync_int = 1'b1; asy_sync_reset = 1'b0;
      asy_startup_delay = 0; asy_frame_length = 2; asy_burst_count = 0;
      asy_enable = 1'b1;
      wait_run(1);
      asy_enable = 1'b0;
      step_cmp();
      chk("dis_enable_low", tdd.tdd_enable, 0);
      step_cmp();
      chk("dis_cstate", tdd.tdd_cstate, IDLE);
      chk("dis_counter", tdd.tdd_counter, 0);
      chk("dis_eof", tdd.tdd_endof_frame, 0);
      chk("dis_sync", tdd.tdd_sync_out, 0);

      asy_frame_length = 8;
      asy_enable = 1'b1;
      wait_run(3);
      resetn = 1'b0;
      #1;
      chk("arst_enable", tdd.tdd_enable, 0);
      chk("arst_cstate", tdd.tdd_cstate, IDLE);
      chk("arst_counter", tdd.tdd_counter, 0);
      chk("arst_eof", tdd.tdd_endof_frame, 0);
      chk("arst_sync", tdd.tdd_sync_out, 0);
      @(negedge clk);
      resetn = 1'b1;
      step_cmp();
      chk("arst_rel_enable", tdd.tdd_enable, 1);
      chk("arst_rel_idle", tdd.tdd_cstate, IDLE);
      step_cmp();
      chk("arst_rearm", tdd.tdd_cstate, ARMED);

      for (int n = 0; n < 2000; n++) begin
         if (n % 64 == 0) begin
            asy_sync_int      = 1'($urandom_range(0, 1));
            asy_sync_reset    = 1'($urandom_range(0, 1));
            asy_startup_delay = $urandom_range(0, 4);
            asy_frame_length  = $urandom_range(0, 6);
            asy_burst_count   = $urandom_range(0, 3);
         end
         if (asy_enable) asy_enable = ($urandom_range(0, 49) != 0);
         else            asy_enable = ($urandom_range(0, 3) == 0);
         sync_soft = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 4) == 0) sync_ext = ~sync_ext;
         step_cmp();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
